cic_output_scaler: RTL and testbench

CIC_OUTPUT_SCALER -- requirements
Module: cic_output_scaler

---
 rtl/cic_output_scaler.sv | 159 +++++++++++++++
 tb/tb_cic_output_scaler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_output_scaler.sv
// CIC interpolator output scaler: rounding arithmetic right shift, saturation to the
// DAC width and a small first-word-fall-through output FIFO with credit-style accept.
// Optional sticky clip counter enabled by defining CIC_OUTPUT_SCALER_SAT_COUNT_EN.
module cic_output_scaler #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 12,
  parameter int DEPTH     = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic signed [IN_WIDTH-1:0]  i_inph_data,
  input  logic signed [IN_WIDTH-1:0]  i_quad_data,
  input  logic                        i_ready,
  output logic                        o_accept,
  input  logic [3:0]                  i_shift,
  output logic signed [OUT_WIDTH-1:0] o_inph_data,
  output logic signed [OUT_WIDTH-1:0] o_quad_data,
  output logic                        o_ready,
  input  logic                        i_dac_ready,
  output logic                        o_sat,
  output logic                        o_drop,
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
  output logic [15:0]                 o_sat_count,
`endif
  input  logic                        i_flag_clear
);

  localparam int XW = IN_WIDTH + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

  // One extra bit of headroom keeps x + 2^(sh-1) from wrapping at full scale.
  function automatic logic signed [XW-1:0] round_shift(input logic signed [IN_WIDTH-1:0] x,
                                                       input logic [3:0] sh);
    logic signed [XW-1:0] xe;
    logic signed [XW-1:0] rnd;
    logic signed [XW-1:0] sum;
    xe  = {x[IN_WIDTH-1], x};
    rnd = '0;
    if (sh != 4'd0) rnd = {{(XW-1){1'b0}}, 1'b1} << (sh - 4'd1);
    sum = xe + rnd;
    return sum >>> sh;
  endfunction

  function automatic logic clipped(input logic signed [XW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [XW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  logic                        vld_p1_q, vld_p1_d;
  logic                        vld_p2_q, vld_p2_d;
  logic signed [XW-1:0]        inph_p1_q, quad_p1_q;
  logic signed [OUT_WIDTH-1:0] inph_p2_q, quad_p2_q;
  logic signed [OUT_WIDTH-1:0] mem_inph_q [DEPTH];
  logic signed [OUT_WIDTH-1:0] mem_quad_q [DEPTH];
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [CW-1:0]               occ;
  logic                        accept_q, accept_d;
  logic                        sat_q, sat_d;
  logic                        drop_q, drop_d;
  logic                        accept_fire, push, pop, clip_now;
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
  logic [15:0]                 cnt_q, cnt_d;
`endif

  assign accept_fire = i_ready && accept_q;
  assign o_ready     = (count_q != '0);
  assign push        = vld_p2_q;
  assign pop         = o_ready && i_dac_ready;
  assign clip_now    = vld_p1_q && (clipped(inph_p1_q) || clipped(quad_p1_q));

  always_comb begin
    vld_p1_d = accept_fire;
    vld_p2_d = vld_p1_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Samples in the two pipeline stages already own a FIFO slot.
    occ      = count_d + CW'(vld_p1_d) + CW'(vld_p2_d);
    accept_d = occ < CW'(DEPTH);
    sat_d    = i_flag_clear ? 1'b0 : (sat_q | clip_now);
    drop_d   = i_flag_clear ? 1'b0 : (drop_q | (i_ready && !accept_q));
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
    cnt_d    = cnt_q;
    if (i_flag_clear)                       cnt_d = '0;
    else if (clip_now && cnt_q != 16'hFFFF) cnt_d = cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      accept_q <= 1'b1;
      sat_q    <= 1'b0;
      drop_q   <= 1'b0;
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      accept_q <= accept_d;
      sat_q    <= sat_d;
      drop_q   <= drop_d;
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_ff @(posedge i_clock) begin
    // p1: rounded shift, shift amount taken on the accept cycle
    if (accept_fire) begin
      inph_p1_q <= round_shift(i_inph_data, i_shift);
      quad_p1_q <= round_shift(i_quad_data, i_shift);
    end
    // p2: clamp to the DAC range
    if (vld_p1_q) begin
      inph_p2_q <= saturate(inph_p1_q);
      quad_p2_q <= saturate(quad_p1_q);
    end
    // FIFO write
    if (vld_p2_q) begin
      mem_inph_q[wr_ptr_q] <= inph_p2_q;
      mem_quad_q[wr_ptr_q] <= quad_p2_q;
    end
  end

  assign o_accept    = accept_q;
  assign o_sat       = sat_q;
  assign o_drop      = drop_q;
  assign o_inph_data = o_ready ? mem_inph_q[rd_ptr_q] : '0;
  assign o_quad_data = o_ready ? mem_quad_q[rd_ptr_q] : '0;
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
  assign o_sat_count = cnt_q;
`endif

endmodule

// File: tb/tb_cic_output_scaler.sv
// Scoreboard bench for cic_output_scaler (IN_WIDTH=16, OUT_WIDTH=12, DEPTH=4):
// stimulus pushes expected {I,Q} words, a monitor pops them on every DUT pop.
module tb_cic_output_scaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_i, in_q;
  logic        rdy;
  wire         acc;
  logic [3:0]  sh;
  wire  [11:0] out_i, out_q;
  wire         ordy;
  logic        dac;
  wire         sat, drop;
  logic        clr;
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
  wire  [15:0] sat_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  cic_output_scaler #(.IN_WIDTH(16), .OUT_WIDTH(12), .DEPTH(4)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_inph_data(in_i), .i_quad_data(in_q),
    .i_ready(rdy), .o_accept(acc), .i_shift(sh),
    .o_inph_data(out_i), .o_quad_data(out_q), .o_ready(ordy),
    .i_dac_ready(dac), .o_sat(sat), .o_drop(drop),
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
    .o_sat_count(sat_cnt),
`endif
    .i_flag_clear(clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] xi, input logic [15:0] xq, input logic [3:0] s,
                      input logic [11:0] ei, input logic [11:0] eq);
    in_i = xi; in_q = xq; sh = s; rdy = 1'b1;
    exp_q.push_back({ei, eq});
    tick();
    rdy = 1'b0;
  endtask

  // Monitor: a pop happens on the next rising edge whenever o_ready && i_dac_ready.
  always @(negedge clk) begin
    if (rst_n && ordy && dac) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h/%h expected none", out_i, out_q);
      end else begin
        e = exp_q.pop_front();
        if ({out_i, out_q} !== e) begin
          errors++;
          $display("FAIL output_data: got %h/%h expected %h/%h", out_i, out_q, e[23:12], e[11:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_i = '0; in_q = '0; rdy = 1'b0; sh = '0; dac = 1'b0; clr = 1'b0;
    tick(); tick();
    check("rst_ready", ordy, 0);
    check("rst_accept", acc, 1);
    check("rst_sat", sat, 0);
    check("rst_drop", drop, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    rst_n = 1'b1;
    tick();

    // Pops against an empty FIFO are ignored
    dac = 1'b1;
    tick(); tick();
    check("empty_pop_ready", ordy, 0);
    dac = 1'b0;

    // Latency: accept edge, then two more edges before o_ready
    send(16'h0008, 16'hFFE8, 4'd4, 12'h001, 12'hFFF);
    check("lat_e0", ordy, 0);
    tick();
    check("lat_e1", ordy, 0);
    tick();
    check("lat_e2", ordy, 1);
    check("lat_out_i", out_i, 12'h001);
    check("lat_out_q", out_q, 12'hFFF);
    check("lat_sat", sat, 0);
    dac = 1'b1;
    tick();

    // Full-scale saturation and flag clear
    send(16'h7FFF, 16'h8000, 4'd0, 12'h7FF, 12'h800);
    tick(); tick(); tick();
    check("sat_set", sat, 1);
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
    check("sat_count_1", sat_cnt, 1);
`endif
    clr = 1'b1; tick(); clr = 1'b0;
    check("sat_cleared", sat, 0);
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
    check("sat_count_cleared", sat_cnt, 0);
`endif

    // Clear wins over a clip in the same cycle
    send(16'h0800, 16'hF7FF, 4'd0, 12'h7FF, 12'h800);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clear_priority", sat, 0);
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
    check("clear_priority_cnt", sat_cnt, 0);
`endif
    tick(); tick();

    // Back-to-back samples with differing shifts; range edges without clipping
    send(16'h0003, 16'hFFFD, 4'd1,  12'h002, 12'hFFF);
    send(16'h4000, 16'h8000, 4'd15, 12'h001, 12'hFFF);
    send(16'h3FF8, 16'hC000, 4'd3,  12'h7FF, 12'h800);
    send(16'h0006, 16'hFFFA, 4'd2,  12'h002, 12'hFFF);
    tick(); tick(); tick();
    check("no_clip_boundary", sat, 0);

    // Rounding carries just over the top
    send(16'h3FFC, 16'h0000, 4'd3, 12'h7FF, 12'h000);
    tick(); tick(); tick();
    check("round_clip_sat", sat, 1);
`ifdef CIC_OUTPUT_SCALER_SAT_COUNT_EN
    check("round_clip_cnt", sat_cnt, 1);
`endif
    clr = 1'b1; tick(); clr = 1'b0;

    // Backpressure: six strobes, four accepted, two dropped
    dac = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("drop_accept", acc, (k < 4) ? 1 : 0);
      in_i = 16'(k + 1); in_q = 16'(0 - (k + 1)); sh = 4'd0; rdy = 1'b1;
      if (k < 4) exp_q.push_back({12'(k + 1), 12'(0 - (k + 1))});
      tick();
    end
    rdy = 1'b0;
    tick(); tick(); tick();
    check("drop_flag", drop, 1);
    check("drop_full_ready", ordy, 1);
    dac = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("drop_drained", ordy, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("drop_cleared", drop, 0);

    // Fill, then stream one per cycle across pointer wrap
    dac = 1'b0;
    for (int n = 0; n < 4; n++)
      send(16'(16'h100 + n), 16'(16'h200 + n), 4'd0, 12'(12'h100 + n), 12'(12'h200 + n));
    tick(); tick(); tick();
    check("fill_accept", acc, 0);
    check("fill_ready", ordy, 1);
    dac = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("stream_ready", ordy, 1);
      check("stream_accept", acc, (c == 0) ? 0 : 1);
      if (c == 0) rdy = 1'b0;
      else begin
        in_i = 16'(16'h100 + 3 + c); in_q = 16'(16'h200 + 3 + c); sh = 4'd0; rdy = 1'b1;
        exp_q.push_back({12'(12'h100 + 3 + c), 12'(12'h200 + 3 + c)});
      end
      tick();
    end
    rdy = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("stream_no_drop", drop, 0);
    check("stream_drained", ordy, 0);

    // Reset with three samples buffered
    dac = 1'b0;
    send(16'h7FFF, 16'h0000, 4'd0, 12'h7FF, 12'h000);
    send(16'h0005, 16'h0006, 4'd0, 12'h005, 12'h006);
    send(16'h0010, 16'h0020, 4'd4, 12'h001, 12'h002);
    tick(); tick(); tick();
    check("prereset_ready", ordy, 1);
    check("prereset_sat", sat, 1);
    rst_n = 1'b0;
    #1;
    check("reset_ready_now", ordy, 0);
    check("reset_out_i", out_i, 0);
    exp_q.delete();
    tick();
    check("reset_accept", acc, 1);
    check("reset_sat", sat, 0);
    check("reset_drop", drop, 0);
    rst_n = 1'b1;
    dac = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("post_reset_idle", ordy, 0);
    send(16'h0006, 16'hFFFA, 4'd2, 12'h002, 12'hFFF);
    tick(); tick(); tick(); tick();
    check("post_reset_drained", ordy, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
